// File: rtl/pix_fifo_pkg.sv
// Shared constants for the pixel FIFO: default geometry and depth helper.
package pix_fifo_pkg;

  localparam int W_DEF = 16;  // pixel word width
  localparam int N_DEF = 8;   // address width

  // Number of words addressed by an n-bit pointer.
  function automatic int depth_of(input int n);
    return 32'sd1 << n;
  endfunction

  localparam int DEPTH_DEF = depth_of(N_DEF);

endpackage

// File: rtl/pix_fifo_ram.sv
// Simple dual-port 2^N x W memory: one synchronous write port and one
// registered read port with read-before-write behaviour (iCE40 SB_RAM style).
module pix_fifo_ram #(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [N-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [N-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem_q [0:(1<<N)-1];
  logic [W-1:0] rdata_q;

  // Storage write and registered read; a same-address read returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pix_fifo.sv
// First-word-fall-through pixel FIFO. Every word lives in the RAM; the head
// word is presented either from the RAM read register or, when the head slot
// is written on the same edge it becomes head, from a one-cycle bypass register.
module pix_fifo
  import pix_fifo_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  output logic         rst_done,
  input  logic         w_trigger,
  input  logic [W-1:0] w_data,
  output logic         w_ready,
  input  logic         r_trigger,
  output logic         r_ready,
  output logic [W-1:0] r_data
);

  localparam logic [N:0]   FULL_CNT = (N+1)'(depth_of(N));
  localparam logic [N:0]   ZERO_CNT = (N+1)'(0);
  localparam logic [N:0]   CNT_ONE  = (N+1)'(1);
  localparam logic [N-1:0] PTR_ONE  = N'(1);

  logic [1:0]   rst_sync_q;
  logic         rst_release;
  logic         rst_done_q;
  logic [N-1:0] wr_ptr_q, wr_ptr_d;
  logic [N-1:0] rd_ptr_q, rd_ptr_d;
  logic [N:0]   count_q, count_d;
  logic         byp_sel_q, byp_sel_d;
  logic [W-1:0] byp_data_q, byp_data_d;
  logic [W-1:0] ram_rdata;
  logic         wr_en;
  logic         rd_en;

  // Reset synchronizer: set at once by rst, cleared two edges after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  // High only on the edge where the synchronized reset releases.
  assign rst_release = rst_sync_q[1] & ~rst_sync_q[0];

  // Session marker: flips once per completed reset, deliberately untouched by rst.
  always_ff @(posedge clk) begin
    if (rst_release) begin
      rst_done_q <= ~rst_done_q;
    end else begin
      rst_done_q <= rst_done_q;
    end
  end

  assign rst_done = rst_done_q;
  assign w_ready  = ~rst_sync_q[1] & (count_q != FULL_CNT);
  assign r_ready  = (count_q != ZERO_CNT);
  assign wr_en    = w_trigger & w_ready;
  assign rd_en    = r_trigger & r_ready;

  // Next pointers, occupancy and head-bypass selection.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    byp_sel_d  = 1'b0;
    byp_data_d = byp_data_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // The slot being written is the next head: the RAM read would see stale data.
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      byp_sel_d  = 1'b1;
      byp_data_d = w_data;
    end else begin
      byp_sel_d  = 1'b0;
      byp_data_d = byp_data_q;
    end
  end

  // FIFO state registers, cleared asynchronously so r_ready drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {N{1'b0}};
      rd_ptr_q   <= {N{1'b0}};
      count_q    <= {(N+1){1'b0}};
      byp_sel_q  <= 1'b0;
      byp_data_q <= {W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      byp_sel_q  <= byp_sel_d;
      byp_data_q <= byp_data_d;
    end
  end

  // The RAM prefetches the word that will be head after this edge.
  pix_fifo_ram #(
    .W(W),
    .N(N)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (w_data),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  assign r_data = r_ready ? (byp_sel_q ? byp_data_q : ram_rdata) : {W{1'b0}};

endmodule

// File: tb/tb_pix_fifo.sv
// Self-checking bench for pix_fifo: a queue-based reference model is stepped
// once per clock and DUT outputs are compared on the falling edge.
module tb_pix_fifo;
  import pix_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_done;
  logic        w_trigger = 1'b0;
  logic [15:0] w_data = 16'h0000;
  logic        w_ready;
  logic        r_trigger = 1'b0;
  logic        r_ready;
  logic [15:0] r_data;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_q[$];
  logic        m_blocked  = 1'b0;
  logic        m_rst_done = 1'b0;

  int n_wstall = 0;  // DUT-observed: write attempted while w_ready low
  int n_pop    = 0;  // DUT-observed: accepted reads
  int n_wacc   = 0;  // DUT-observed: accepted writes

  pix_fifo #(.W(16), .N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rst_done  (rst_done),
    .w_trigger (w_trigger),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .r_trigger (r_trigger),
    .r_ready   (r_ready),
    .r_data    (r_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of traffic: entered just after a falling edge, leaves just after the next one.
  task automatic cycle(input logic wt, input logic [15:0] wd, input logic rt);
    logic exp_w;
    logic exp_r;
    w_trigger = wt;
    w_data    = wd;
    r_trigger = rt;
    exp_w = wt && !m_blocked && (m_q.size() < DEPTH_DEF);
    exp_r = rt && (m_q.size() != 0);
    if (wt && !w_ready) n_wstall++;
    if (wt && w_ready)  n_wacc++;
    if (rt && r_ready)  n_pop++;
    @(posedge clk);
    if (exp_r) void'(m_q.pop_front());
    if (exp_w) m_q.push_back(wd);
    @(negedge clk);
    chk("w_ready", w_ready, !m_blocked && (m_q.size() < DEPTH_DEF));
    chk("r_ready", r_ready, m_q.size() != 0);
    if (m_q.size() != 0) chk("r_data", r_data, m_q[0]);
    chk("rst_done", rst_done, m_rst_done);
  endtask

  // Reset pulse with triggers held high throughout; hold_cycles=0 gives a sub-period pulse.
  task automatic do_reset(input int hold_cycles);
    w_trigger = 1'b1;
    r_trigger = 1'b1;
    w_data    = 16'($urandom);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rready", r_ready, 1'b0);
    chk("rst_wready", w_ready, 1'b0);
    chk("rst_rdata", r_data, 16'h0000);
    if (hold_cycles == 0) begin
      #1;
      rst = 1'b0;
    end else begin
      for (int i = 0; i < hold_cycles; i++) @(negedge clk);
      chk("rst_hold_wready", w_ready, 1'b0);
      #2;
      rst = 1'b0;
    end
    m_q.delete();
    m_blocked = 1'b1;
    @(posedge clk);
    #1;
    chk("rel1_wready", w_ready, 1'b0);
    chk("rel1_rready", r_ready, 1'b0);
    chk("rel1_rst_done", rst_done, m_rst_done);
    @(posedge clk);
    #1;
    m_blocked  = 1'b0;
    m_rst_done = ~m_rst_done;
    chk("rel2_wready", w_ready, 1'b1);
    chk("rel2_rready", r_ready, 1'b0);
    chk("rel2_rst_done", rst_done, m_rst_done);
    w_trigger = 1'b0;
    r_trigger = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    int drained;
    int wp;
    int rp;
    int cyc;
    int occ_max;
    logic [15:0] first;

    // Power-up state before any reset
    #1;
    chk("pwr_wready", w_ready, 1'b1);
    chk("pwr_rready", r_ready, 1'b0);
    chk("pwr_rst_done", rst_done, 1'b0);
    @(negedge clk);

    // Sub-period reset pulse: full reset and one toggle (0 -> 1)
    do_reset(0);
    chk("init_rst_done", rst_done, 1'b1);

    // 1. Stream 4607..0 with the consumer reading every cycle
    n_wstall = 0;
    base = n_pop;
    for (int i = 0; i < 4608; i++) cycle(1'b1, 16'(4607 - i), 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("s1_stalls", n_wstall, 0);
    chk("s1_received", n_pop - base, 4608);
    chk("s1_rst_done", rst_done, 1'b1);

    // 4. No extra data after the stream drains
    for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0000, 1'b0);

    // 2. Fill to 256 with no reads, then a dropped 257th write
    for (int i = 0; i < 256; i++) cycle(1'b1, 16'(i), 1'b0);
    chk("s2_full_wready", w_ready, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b0);

    // 3. Simultaneous write and read while full: read wins, write dropped
    cycle(1'b1, 16'h1234, 1'b1);
    chk("s3_wready", w_ready, 1'b1);
    chk("s3_head", r_data, 16'h0001);
    drained = 0;
    while (r_ready && drained < 300) begin
      cycle(1'b0, 16'h0000, 1'b1);
      drained++;
    end
    chk("s3_drained", drained, 255);

    // 5. Reset with 100 words queued
    for (int i = 0; i < 100; i++) cycle(1'b1, 16'($urandom), 1'b0);
    do_reset(1);
    first = 16'($urandom);
    cycle(1'b1, first, 1'b0);
    chk("s5_first", r_data, first);
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'($urandom), 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 16'h0000, 1'b1);
    chk("s5_empty", r_ready, 1'b0);

    // 6. Random duty: 1000 writes, alternating write-heavy and read-heavy phases
    base = n_pop;
    n_wacc = 0;
    occ_max = 0;
    cyc = 0;
    while (n_wacc < 1000 && cyc < 20000) begin
      if (((cyc / 300) % 2) == 0) begin
        wp = 90; rp = 30;
      end else begin
        wp = 30; rp = 90;
      end
      cycle(($urandom_range(0, 99) < wp) && (n_wacc < 1000), 16'($urandom),
            $urandom_range(0, 99) < rp);
      if ((n_wacc - (n_pop - base)) > occ_max) occ_max = n_wacc - (n_pop - base);
      cyc++;
    end
    cyc = 0;
    while (r_ready && cyc < 400) begin
      cycle(1'b0, 16'h0000, 1'b1);
      cyc++;
    end
    chk("s6_writes", n_wacc, 1000);
    chk("s6_reads", n_pop - base, 1000);
    chk("s6_occ_le_256", occ_max <= 256, 1'b1);
    chk("final_rst_done", rst_done, m_rst_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
